// File: rtl/stopwatch_button_debouncer.sv
// Push-button debouncer: optional 2-flop synchroniser, then a 4-state stability FSM with registered level/rise/fall.
// Define DEBOUNCE_SYNC_EN to insert the synchroniser ahead of the FSM.
module stopwatch_button_debouncer #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES) + 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    if (STABLE_CYCLES < 1) begin : g_bad_param
        $error("STABLE_CYCLES must be at least 1");
    end

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(1);
    localparam bit               SINGLE    = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        PEND_HIGH,
        STABLE_HIGH,
        PEND_LOW
    } state_t;

    logic             sample;
    state_t           state;
    logic [CNT_W-1:0] cnt;

`ifdef DEBOUNCE_SYNC_EN
    logic sync_p0;
    logic sync_p1;

    // Synchroniser stage: btn_i is asynchronous to clk_i
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn_i;
            sync_p1 <= sync_p0;
        end
    end

    assign sample = sync_p1;
`else
    assign sample = btn_i;
`endif

    // Stability FSM: cnt counts consecutive samples that differ from the accepted level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= STABLE_LOW;
            cnt     <= '0;
            level_o <= 1'b0;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            unique case (state)
                STABLE_LOW: begin
                    if (!sample) begin
                        cnt <= '0;
                    end else if (SINGLE) begin
                        state   <= STABLE_HIGH;
                        cnt     <= '0;
                        level_o <= 1'b1;
                        rise_o  <= 1'b1;
                    end else begin
                        state <= PEND_HIGH;
                        cnt   <= CNT_FIRST;
                    end
                end
                PEND_HIGH: begin
                    if (!sample) begin
                        state <= STABLE_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= STABLE_HIGH;
                        cnt     <= '0;
                        level_o <= 1'b1;
                        rise_o  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (sample) begin
                        cnt <= '0;
                    end else if (SINGLE) begin
                        state   <= STABLE_LOW;
                        cnt     <= '0;
                        level_o <= 1'b0;
                        fall_o  <= 1'b1;
                    end else begin
                        state <= PEND_LOW;
                        cnt   <= CNT_FIRST;
                    end
                end
                PEND_LOW: begin
                    if (sample) begin
                        state <= STABLE_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state   <= STABLE_LOW;
                        cnt     <= '0;
                        level_o <= 1'b0;
                        fall_o  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= STABLE_LOW;
                    cnt     <= '0;
                    level_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_button_debouncer.sv
// Scoreboard bench for stopwatch_button_debouncer with STABLE_CYCLES=4; adapts latency to DEBOUNCE_SYNC_EN.
module tb_stopwatch_button_debouncer;

    localparam int S = 4;
`ifdef DEBOUNCE_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 0;
`endif
    localparam int LAT = S + D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic level;
    logic rise;
    logic fall;

    stopwatch_button_debouncer #(.STABLE_CYCLES(S)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_i   (btn),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int last_rise_cyc = -1;
    int last_fall_cyc = -1;

    logic [2:0] exp_q[$];
    logic [2:0] exp_v;

    // Behavioural reference: input delay of D samples, then accept a level after S consecutive differing samples
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    logic m_lvl = 1'b0;
    int   m_run = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic b, input logic r);
        logic smp;
        logic m_rise;
        logic m_fall;
        @(negedge clk);
        btn = b;
        rst = r;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (r) begin
            m_s1  = 1'b0;
            m_s2  = 1'b0;
            m_lvl = 1'b0;
            m_run = 0;
        end else begin
            smp  = (D == 2) ? m_s2 : b;
            m_s2 = m_s1;
            m_s1 = b;
            if (smp != m_lvl) begin
                m_run++;
                if (m_run == S) begin
                    m_lvl  = smp;
                    m_rise = smp;
                    m_fall = ~smp;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        exp_q.push_back({m_lvl, m_rise, m_fall});
    endtask

    task automatic hold(input logic b, input int n);
        for (int i = 0; i < n; i++) drive(b, 1'b0);
    endtask

    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (rise === 1'b1) begin
            rise_cnt++;
            last_rise_cyc = cyc;
        end
        if (fall === 1'b1) begin
            fall_cnt++;
            last_fall_cyc = cyc;
        end
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            check_eq("level", 32'(level), 32'(exp_v[2]));
            check_eq("rise", 32'(rise), 32'(exp_v[1]));
            check_eq("fall", 32'(fall), 32'(exp_v[0]));
        end
    end

    initial begin
        int e0;
        int bounce[5];
        logic v;
        bounce = '{1, 0, 1, 1, 0};

        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1);
        check_eq("reset_level", 32'(level), 0);
        hold(1'b0, 3);

        // clean press
        drive(1'b1, 1'b0);
        e0 = cyc + 1;
        hold(1'b1, LAT + 4);
        check_eq("press_rise_cnt", rise_cnt, 1);
        check_eq("press_fall_cnt", fall_cnt, 0);
        check_eq("press_latency", last_rise_cyc - e0, LAT - 1);

        // release
        drive(1'b0, 1'b0);
        e0 = cyc + 1;
        hold(1'b0, LAT + 4);
        check_eq("release_fall_cnt", fall_cnt, 1);
        check_eq("release_latency", last_fall_cyc - e0, LAT - 1);

        // short high glitch
        hold(1'b1, 3);
        hold(1'b0, LAT + 4);
        check_eq("glitch_rise_cnt", rise_cnt, 1);
        check_eq("glitch_level", 32'(level), 0);

        // bounce then settle high
        for (int i = 0; i < 5; i++) drive(bounce[i][0], 1'b0);
        drive(1'b1, 1'b0);
        e0 = cyc + 1;
        hold(1'b1, LAT + 6);
        check_eq("bounce_rise_cnt", rise_cnt, 2);
        check_eq("bounce_fall_cnt", fall_cnt, 1);
        check_eq("bounce_latency", last_rise_cyc - e0, LAT - 1);

        // short low glitch while high
        hold(1'b0, 3);
        hold(1'b1, LAT + 4);
        check_eq("glitch_lo_fall_cnt", fall_cnt, 1);
        check_eq("glitch_lo_level", 32'(level), 1);

        drive(1'b0, 1'b0);
        e0 = cyc + 1;
        hold(1'b0, LAT + 4);
        check_eq("release2_fall_cnt", fall_cnt, 2);
        check_eq("release2_latency", last_fall_cyc - e0, LAT - 1);

        // reset while pending high with cnt=2, button kept high
        hold(1'b1, D + 2);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        e0 = cyc + 1;
        hold(1'b1, LAT + 4);
        check_eq("rstpend_rise_cnt", rise_cnt, 3);
        check_eq("rstpend_latency", last_rise_cyc - e0, LAT - 1);
        hold(1'b0, LAT + 4);
        check_eq("rstpend_fall_cnt", fall_cnt, 3);

        // random bounce runs, checked cycle by cycle against the reference
        v = 1'b0;
        for (int r = 0; r < 60; r++) begin
            v = ~v;
            hold(v, $urandom_range(1, 7));
        end
        hold(1'b0, LAT + 4);
        check_eq("final_level", 32'(level), 0);

        repeat (2) @(negedge clk);
        check_eq("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
